// File: rtl/scoreboard_hazard_unit.sv
// Scoreboard hazard unit: DEPTH-slot in-flight write table driving RAW stall, forwarding selects and a deferred IRQ flush.
// Latency: stall/fwd are combinational off the registered table; table, occupancy and IRQ outputs are registered.
// Backpressure: stall_ext freezes the table; a RAW hit refuses the issue and a bubble enters slot 0.

module scoreboard_hazard_unit #(
  parameter int DEPTH = 3,
  parameter int NREGS = 32,
  parameter int REG_W = $clog2(NREGS),
  parameter int SEL_W = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             issue_valid,
  input  logic             issue_wen,
  input  logic [REG_W-1:0] issue_rd,
  input  logic [SEL_W-1:0] issue_rdy,
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  input  logic             rs1_used,
  input  logic             rs2_used,
  input  logic             stall_ext,
  input  logic [DEPTH-1:0] flush_mask,
  input  logic             mem_busy,
  input  logic             irq_req,
  input  logic             exc,
  output logic             issue_stall,
  output logic [SEL_W-1:0] fwd_sel1,
  output logic [SEL_W-1:0] fwd_sel2,
  output logic             irq_flush,
  output logic             irq_pending,
  output logic [SEL_W-1:0] occupancy
);

  if (DEPTH < 2 || DEPTH > 8) begin : g_bad_depth
    $error("scoreboard_hazard_unit: DEPTH must be within 2..8");
  end

  typedef struct packed {
    logic             valid;
    logic             wen;
    logic [REG_W-1:0] rd;
    logic [SEL_W-1:0] rdy;
  } entry_t;

  typedef struct packed {
    logic             stall;
    logic [SEL_W-1:0] fwd;
  } lookup_t;

  typedef enum logic [1:0] {
    IRQ_IDLE  = 2'd0,
    IRQ_DRAIN = 2'd1,
    IRQ_FLUSH = 2'd2
  } irq_state_e;

  entry_t [DEPTH-1:0] tbl_q;
  entry_t [DEPTH-1:0] tbl_d;
  entry_t             issue_ent;
  lookup_t            look1;
  lookup_t            look2;
  irq_state_e         irq_state_q;
  logic               irq_flush_q;
  logic               irq_pending_q;

  // Walk oldest to youngest so the youngest matching writer overrides any older one.
  function automatic lookup_t lookup(input entry_t [DEPTH-1:0] tbl,
                                     input logic              used,
                                     input logic [REG_W-1:0]  rs);
    lookup_t          res;
    logic             hit;
    logic [SEL_W-1:0] slot;
    logic [SEL_W-1:0] rdy;
    res  = '0;
    hit  = 1'b0;
    slot = '0;
    rdy  = '0;
    for (int s = DEPTH - 1; s >= 0; s--) begin
      if (tbl[s].valid && tbl[s].wen && (tbl[s].rd == rs)) begin
        hit  = 1'b1;
        slot = SEL_W'(s);
        rdy  = tbl[s].rdy;
      end
    end
    if (used && (rs != '0) && hit) begin
      if (slot >= rdy) begin
        res.fwd = slot;
      end else begin
        res.stall = 1'b1;
      end
    end
    return res;
  endfunction

  always_comb begin
    look1       = lookup(tbl_q, rs1_used, rs1);
    look2       = lookup(tbl_q, rs2_used, rs2);
    issue_stall = look1.stall | look2.stall;
    fwd_sel1    = look1.fwd;
    fwd_sel2    = look2.fwd;
  end

  // x0 writes are architecturally discarded, so they never create a dependency.
  always_comb begin
    issue_ent       = '0;
    issue_ent.valid = 1'b1;
    issue_ent.wen   = issue_wen && (issue_rd != '0);
    issue_ent.rd    = issue_rd;
    issue_ent.rdy   = issue_rdy;
  end

  always_comb begin
    tbl_d = tbl_q;
    if (|flush_mask) begin
      if (stall_ext) begin
        for (int s = 0; s < DEPTH; s++) begin
          if (flush_mask[s]) begin
            tbl_d[s] = '0;
          end
        end
      end else begin
        tbl_d[0] = '0;
        for (int s = 1; s < DEPTH; s++) begin
          if (flush_mask[s-1]) begin
            tbl_d[s] = '0;
          end else begin
            tbl_d[s] = tbl_q[s-1];
          end
        end
      end
    end else if (!stall_ext) begin
      if (issue_valid && !issue_stall) begin
        tbl_d[0] = issue_ent;
      end else begin
        tbl_d[0] = '0;
      end
      for (int s = 1; s < DEPTH; s++) begin
        tbl_d[s] = tbl_q[s-1];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      tbl_q <= '0;
    end else begin
      tbl_q <= tbl_d;
    end
  end

  always_comb begin
    occupancy = '0;
    for (int s = 0; s < DEPTH; s++) begin
      occupancy = occupancy + SEL_W'(tbl_q[s].valid);
    end
  end

  // An exception always beats the interrupt; the privilege block re-raises irq_req later.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      irq_state_q   <= IRQ_IDLE;
      irq_flush_q   <= 1'b0;
      irq_pending_q <= 1'b0;
    end else begin
      case (irq_state_q)
        IRQ_IDLE: begin
          if (irq_req && !exc) begin
            irq_pending_q <= 1'b1;
            if (mem_busy) begin
              irq_state_q <= IRQ_DRAIN;
              irq_flush_q <= 1'b0;
            end else begin
              irq_state_q <= IRQ_FLUSH;
              irq_flush_q <= 1'b1;
            end
          end else begin
            irq_state_q   <= IRQ_IDLE;
            irq_flush_q   <= 1'b0;
            irq_pending_q <= 1'b0;
          end
        end
        IRQ_DRAIN: begin
          if (exc) begin
            irq_state_q   <= IRQ_IDLE;
            irq_flush_q   <= 1'b0;
            irq_pending_q <= 1'b0;
          end else if (!mem_busy) begin
            irq_state_q   <= IRQ_FLUSH;
            irq_flush_q   <= 1'b1;
            irq_pending_q <= 1'b1;
          end else begin
            irq_state_q   <= IRQ_DRAIN;
            irq_flush_q   <= 1'b0;
            irq_pending_q <= 1'b1;
          end
        end
        IRQ_FLUSH: begin
          irq_state_q   <= IRQ_IDLE;
          irq_flush_q   <= 1'b0;
          irq_pending_q <= 1'b0;
        end
        default: begin
          irq_state_q   <= IRQ_IDLE;
          irq_flush_q   <= 1'b0;
          irq_pending_q <= 1'b0;
        end
      endcase
    end
  end

  assign irq_flush   = irq_flush_q;
  assign irq_pending = irq_pending_q;

endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// Directed bench for scoreboard_hazard_unit (DEPTH = 3): expectations queued at stimulus time, popped against DUT outputs.
module tb_scoreboard_hazard_unit;

  localparam int DEPTH = 3;
  localparam int REG_W = 5;
  localparam int SEL_W = 2;

  logic             CLK = 1'b0;
  logic             nRST;
  logic             issue_valid;
  logic             issue_wen;
  logic [REG_W-1:0] issue_rd;
  logic [SEL_W-1:0] issue_rdy;
  logic [REG_W-1:0] rs1;
  logic [REG_W-1:0] rs2;
  logic             rs1_used;
  logic             rs2_used;
  logic             stall_ext;
  logic [DEPTH-1:0] flush_mask;
  logic             mem_busy;
  logic             irq_req;
  logic             exc;
  logic             issue_stall;
  logic [SEL_W-1:0] fwd_sel1;
  logic [SEL_W-1:0] fwd_sel2;
  logic             irq_flush;
  logic             irq_pending;
  logic [SEL_W-1:0] occupancy;

  int         n_cmp = 0;
  int         n_bad = 0;
  string      tag_q[$];
  logic [7:0] exp_q[$];

  scoreboard_hazard_unit #(.DEPTH(DEPTH), .NREGS(32)) dut (
    .CLK(CLK), .nRST(nRST),
    .issue_valid(issue_valid), .issue_wen(issue_wen), .issue_rd(issue_rd), .issue_rdy(issue_rdy),
    .rs1(rs1), .rs2(rs2), .rs1_used(rs1_used), .rs2_used(rs2_used),
    .stall_ext(stall_ext), .flush_mask(flush_mask), .mem_busy(mem_busy),
    .irq_req(irq_req), .exc(exc),
    .issue_stall(issue_stall), .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
    .irq_flush(irq_flush), .irq_pending(irq_pending), .occupancy(occupancy)
  );

  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog expired");
  end

  task automatic push(input string tag, input logic [7:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic pop(input logic [7:0] obs);
    string      tag;
    logic [7:0] e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $error("FAIL sb_empty observed=%0d expected=<queued value>", obs);
    end else begin
      tag = tag_q.pop_front();
      e   = exp_q.pop_front();
      assert (obs === e) else begin
        n_bad++;
        $error("FAIL %s observed=%0d expected=%0d", tag, obs, e);
      end
    end
  endtask

  // Call at a negedge; outputs are sampled 1 ns later, away from the rising edge.
  task automatic hz(input string tag, input logic s, input logic [1:0] f1, input logic [1:0] f2);
    push({tag, ".stall"}, 8'(s));
    push({tag, ".fwd1"}, 8'(f1));
    push({tag, ".fwd2"}, 8'(f2));
    #1;
    pop(8'(issue_stall));
    pop(8'(fwd_sel1));
    pop(8'(fwd_sel2));
  endtask

  task automatic occ(input string tag, input logic [1:0] o);
    push({tag, ".occ"}, 8'(o));
    #1;
    pop(8'(occupancy));
  endtask

  task automatic irqs(input string tag, input logic pend, input logic fl);
    push({tag, ".pending"}, 8'(pend));
    push({tag, ".flush"}, 8'(fl));
    #1;
    pop(8'(irq_pending));
    pop(8'(irq_flush));
  endtask

  task automatic tick;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic set_issue(input logic v, input logic [4:0] rd, input logic [1:0] rdy);
    issue_valid = v;
    issue_wen   = v;
    issue_rd    = rd;
    issue_rdy   = rdy;
  endtask

  task automatic set_src(input logic u1, input logic [4:0] r1, input logic u2, input logic [4:0] r2);
    rs1_used = u1;
    rs1      = r1;
    rs2_used = u2;
    rs2      = r2;
  endtask

  initial begin
    nRST = 1'b0;
    set_issue(1'b0, 5'd0, 2'd0);
    set_src(1'b0, 5'd0, 1'b0, 5'd0);
    stall_ext  = 1'b0;
    flush_mask = '0;
    mem_busy   = 1'b0;
    irq_req    = 1'b0;
    exc        = 1'b0;
    repeat (2) @(negedge CLK);

    hz("reset", 1'b0, 2'd0, 2'd0);
    occ("reset", 2'd0);
    irqs("reset", 1'b0, 1'b0);
    nRST = 1'b1;

    // ALU producer x5, one independent op, then the consumer.
    set_issue(1'b1, 5'd5, 2'd1);
    tick;
    set_issue(1'b1, 5'd9, 2'd1);
    tick;
    set_issue(1'b1, 5'd10, 2'd1);
    set_src(1'b1, 5'd5, 1'b0, 5'd0);
    hz("alu_fwd_slot1", 1'b0, 2'd1, 2'd0);
    set_src(1'b1, 5'd5, 1'b1, 5'd9);
    hz("alu_slot0_not_ready", 1'b1, 2'd1, 2'd0);
    tick;
    occ("stall_bubble", 2'd2);
    hz("alu_after_bubble", 1'b0, 2'd2, 2'd1);
    tick;
    occ("alu_issued", 2'd2);

    // Drain, then load-use on x7 with one independent op in between.
    set_issue(1'b0, 5'd0, 2'd0);
    set_src(1'b0, 5'd0, 1'b0, 5'd0);
    repeat (3) tick;
    occ("drained", 2'd0);
    set_issue(1'b1, 5'd7, 2'd2);
    tick;
    set_issue(1'b1, 5'd8, 2'd1);
    tick;
    set_issue(1'b1, 5'd11, 2'd1);
    set_src(1'b1, 5'd7, 1'b0, 5'd0);
    hz("load_use_stall", 1'b1, 2'd0, 2'd0);
    tick;
    hz("load_use_fwd2", 1'b0, 2'd2, 2'd0);
    tick;
    occ("load_use_one_bubble", 2'd2);

    // Two writers of x3: older ready in slot 2, younger not ready in slot 1.
    set_src(1'b0, 5'd0, 1'b0, 5'd0);
    set_issue(1'b1, 5'd3, 2'd1);
    tick;
    set_issue(1'b1, 5'd3, 2'd2);
    tick;
    set_issue(1'b1, 5'd0, 2'd1);
    tick;
    occ("x0_entry_valid", 2'd3);
    set_issue(1'b1, 5'd14, 2'd1);
    set_src(1'b1, 5'd3, 1'b1, 5'd0);
    hz("youngest_wins", 1'b1, 2'd0, 2'd0);
    set_src(1'b0, 5'd3, 1'b1, 5'd0);
    hz("x0_and_unused", 1'b0, 2'd0, 2'd0);

    // Flush slots 0 and 1 while frozen; the issue is dropped.
    set_issue(1'b1, 5'd13, 2'd1);
    set_src(1'b0, 5'd0, 1'b0, 5'd0);
    stall_ext  = 1'b1;
    flush_mask = 3'b011;
    tick;
    stall_ext  = 1'b0;
    flush_mask = '0;
    set_issue(1'b0, 5'd0, 2'd0);
    occ("flush_frozen", 2'd1);
    set_src(1'b1, 5'd3, 1'b1, 5'd13);
    hz("flush_survivor", 1'b0, 2'd2, 2'd0);
    stall_ext = 1'b1;
    tick;
    occ("freeze_hold", 2'd1);
    hz("freeze_hold", 1'b0, 2'd2, 2'd0);
    stall_ext = 1'b0;
    tick;
    occ("retired", 2'd0);
    hz("retired", 1'b0, 2'd0, 2'd0);
    set_src(1'b0, 5'd0, 1'b0, 5'd0);

    // Interrupt deferred by four busy cycles.
    irq_req  = 1'b1;
    mem_busy = 1'b1;
    irqs("irq_idle", 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick;
      irqs($sformatf("irq_drain%0d", i), 1'b1, 1'b0);
    end
    mem_busy = 1'b0;
    irq_req  = 1'b0;
    tick;
    irqs("irq_flush", 1'b1, 1'b1);
    tick;
    irqs("irq_done", 1'b0, 1'b0);

    // Immediate flush when memory is idle; exception blocks acceptance in IDLE.
    irq_req = 1'b1;
    exc     = 1'b1;
    tick;
    irqs("irq_exc_idle", 1'b0, 1'b0);
    exc = 1'b0;
    tick;
    irq_req = 1'b0;
    irqs("irq_direct", 1'b1, 1'b1);
    tick;
    irqs("irq_direct_done", 1'b0, 1'b0);

    // Exception while draining abandons the interrupt.
    irq_req  = 1'b1;
    mem_busy = 1'b1;
    tick;
    irqs("exc_drain_enter", 1'b1, 1'b0);
    exc      = 1'b1;
    irq_req  = 1'b0;
    mem_busy = 1'b0;
    tick;
    irqs("exc_drain_abort", 1'b0, 1'b0);
    exc = 1'b0;
    tick;
    irqs("exc_no_late_flush", 1'b0, 1'b0);

    // Reset with a full table and the FSM draining.
    irq_req  = 1'b1;
    mem_busy = 1'b1;
    set_issue(1'b1, 5'd20, 2'd1);
    tick;
    set_issue(1'b1, 5'd21, 2'd1);
    tick;
    set_issue(1'b1, 5'd22, 2'd1);
    tick;
    occ("full_before_reset", 2'd3);
    irqs("drain_before_reset", 1'b1, 1'b0);
    nRST = 1'b0;
    tick;
    set_src(1'b1, 5'd22, 1'b1, 5'd21);
    occ("mid_reset", 2'd0);
    irqs("mid_reset", 1'b0, 1'b0);
    hz("mid_reset", 1'b0, 2'd0, 2'd0);
    nRST     = 1'b1;
    irq_req  = 1'b0;
    mem_busy = 1'b0;
    set_issue(1'b0, 5'd0, 2'd0);
    tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
